// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator for a 640x480 @ 60 Hz display (timing is parameterised).
// Produces pixel/line counters, active-low sync pulses, an active-video flag,
// a one-clock frame tick at the start of vertical blank and a square wave
// whose period is FRAMES_PER_SEC frames.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ce         pixel-advance enable (tie high when clk is the pixel clock)
//   Hcount     current pixel column, 0..H_TOTAL-1
//   Vcount     current line, 0..V_TOTAL-1
//   Hsync      horizontal sync, active low
//   Vsync      vertical sync, active low
//   active     high inside the visible area
//   frame_tick one-clk pulse on the first cycle at (0, V_ACTIVE)
//   sec        high while the frame counter is in its upper half
//
// All outputs are registered. Sync/active/tick are decoded from the next
// counter values so they line up with the counters on the same cycle.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    output logic [9:0] Hcount,
    output logic [9:0] Vcount,
    output logic       Hsync,
    output logic       Vsync,
    output logic       active,
    output logic       frame_tick,
    output logic       sec
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FW      = $clog2(FRAMES_PER_SEC);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_SEC - 1);
    localparam logic [FW-1:0] F_HALF = FW'(FRAMES_PER_SEC / 2);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (FRAMES_PER_SEC < 2 || (FRAMES_PER_SEC % 2) != 0) begin : g_bad_fps
            $error("vga_timing_gen: FRAMES_PER_SEC must be even and at least 2");
        end
    endgenerate

    logic [9:0]    h_nxt;
    logic [9:0]    v_nxt;
    logic          hs_nxt;
    logic          vs_nxt;
    logic          act_nxt;
    logic          tick_nxt;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] fcnt_nxt;

    always_comb begin
        h_nxt = (Hcount == H_LAST) ? 10'd0 : Hcount + 10'd1;
        v_nxt = Vcount;
        if (Hcount == H_LAST) begin
            v_nxt = (Vcount == V_LAST) ? 10'd0 : Vcount + 10'd1;
        end
        hs_nxt   = !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
        vs_nxt   = !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
        act_nxt  = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        // Only a ce-advance can land on (0, V_ACTIVE), so holding there with
        // ce=0 never re-fires the tick.
        tick_nxt = (h_nxt == 10'd0) && (v_nxt == V_VIS);
        fcnt_nxt = (fcnt == F_LAST) ? '0 : fcnt + FW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Hcount     <= '0;
            Vcount     <= '0;
            Hsync      <= 1'b1;
            Vsync      <= 1'b1;
            active     <= 1'b1;
            frame_tick <= 1'b0;
            sec        <= 1'b0;
            fcnt       <= '0;
        end else if (ce) begin
            Hcount     <= h_nxt;
            Vcount     <= v_nxt;
            Hsync      <= hs_nxt;
            Vsync      <= vs_nxt;
            active     <= act_nxt;
            frame_tick <= tick_nxt;
            if (tick_nxt) begin
                fcnt <= fcnt_nxt;
                sec  <= (fcnt_nxt >= F_HALF);
            end
        end else begin
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

    // Reduced raster for the small instance so whole frames and seconds fit.
    localparam int HA = 20, HFP = 3, HS = 5, HBP = 4;
    localparam int VA = 10, VFP = 2, VS = 3, VBP = 2;
    localparam int FPS = 6;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam logic [24:0] RESET_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;

    logic [9:0] hcount, vcount, f_hcount, f_vcount;
    logic hsync, vsync, active, frame_tick, sec;
    logic f_hsync, f_vsync, f_active, f_frame_tick, f_sec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .FRAMES_PER_SEC(FPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .Hcount(hcount), .Vcount(vcount), .Hsync(hsync), .Vsync(vsync),
        .active(active), .frame_tick(frame_tick), .sec(sec)
    );

    vga_timing_gen dut_full (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .Hcount(f_hcount), .Vcount(f_vcount), .Hsync(f_hsync), .Vsync(f_vsync),
        .active(f_active), .frame_tick(f_frame_tick), .sec(f_sec)
    );

    logic [24:0] obs, obs_f;
    assign obs   = {hcount, vcount, hsync, vsync, active, frame_tick, sec};
    assign obs_f = {f_hcount, f_vcount, f_hsync, f_vsync, f_active, f_frame_tick, f_sec};

    // Reference model: number of pixel advances since reset and number of
    // frame ticks; everything else is derived arithmetically.
    longint pos = 0;
    longint ticks = 0;
    logic   m_tick = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos = 0; ticks = 0; m_tick = 1'b0;
        end else if (ce) begin
            pos = pos + 1;
            m_tick = ((pos % HT) == 0) && (((pos / HT) % VT) == VA);
            if (m_tick) ticks = ticks + 1;
        end else begin
            m_tick = 1'b0;
        end
    end

    function automatic logic [24:0] exp_vec(input longint ps, input int ha, hfp, hsw, hbp,
                                            input int va, vfp, vsw, vbp, fps,
                                            input logic tk, input longint tks);
        int ht, vt, h, v;
        logic hs_e, vs_e, ac_e, sc_e;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        h = int'(ps % ht);
        v = int'((ps / ht) % vt);
        hs_e = !(h >= ha + hfp && h < ha + hfp + hsw);
        vs_e = !(v >= va + vfp && v < va + vfp + vsw);
        ac_e = (h < ha) && (v < va);
        sc_e = (tks % fps) >= (fps / 2);
        return {h[9:0], v[9:0], hs_e, vs_e, ac_e, tk, sc_e};
    endfunction

    function automatic logic [24:0] exp_s();
        return exp_vec(pos, HA, HFP, HS, HBP, VA, VFP, VS, VBP, FPS, m_tick, ticks);
    endfunction

    function automatic logic [24:0] exp_f();
        return exp_vec(pos, 640, 16, 96, 48, 480, 10, 2, 33, 60, 1'b0, 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce = 1'b1;
        repeat (3) step();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL reset_small: got %h expected %h", obs, RESET_VEC);
        end
        checks++;
        if (obs_f !== RESET_VEC) begin
            errors++; $display("FAIL reset_full: got %h expected %h", obs_f, RESET_VEC);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (hcount !== 10'd1 || f_hcount !== 10'd1) begin
            errors++; $display("FAIL first_advance: got %0d/%0d expected 1", hcount, f_hcount);
        end
    endtask

    task automatic test_default_line();
        int act_low, hs_low, hs_first, hs_back;
        do_reset();
        ce = 1'b1;
        act_low = 0; hs_low = 0; hs_first = -1; hs_back = -1;
        for (int i = 0; i < 800; i++) begin
            checks++;
            if (obs_f !== exp_f()) begin
                errors++; $display("FAIL full_line: got %h expected %h at pos %0d", obs_f, exp_f(), pos);
            end
            if (!f_active) act_low++;
            if (!f_hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(f_hcount);
            end else if (hs_first >= 0 && hs_back < 0) begin
                hs_back = int'(f_hcount);
            end
            step();
        end
        checks++;
        if (f_hcount !== 10'd0 || f_vcount !== 10'd1) begin
            errors++; $display("FAIL full_wrap: got (%0d,%0d) expected (0,1)", f_hcount, f_vcount);
        end
        checks++;
        if (act_low != 160) begin
            errors++; $display("FAIL full_active_low: got %0d expected 160", act_low);
        end
        checks++;
        if (hs_low != 96 || hs_first != 656 || hs_back != 752) begin
            errors++; $display("FAIL full_hsync: got len %0d first %0d back %0d expected 96 656 752",
                               hs_low, hs_first, hs_back);
        end
        for (int i = 0; i < 900; i++) begin
            checks++;
            if (obs_f !== exp_f()) begin
                errors++; $display("FAIL full_line2: got %h expected %h at pos %0d", obs_f, exp_f(), pos);
            end
            step();
        end
    endtask

    task automatic test_frame();
        int vs_low, tk_cnt, tk_h, tk_v, wraps;
        logic [9:0] ph, pv;
        do_reset();
        ce = 1'b1;
        vs_low = 0; tk_cnt = 0; tk_h = -1; tk_v = -1; wraps = 0;
        ph = hcount; pv = vcount;
        for (int i = 0; i <= FRAME; i++) begin
            checks++;
            if (obs !== exp_s()) begin
                errors++; $display("FAIL frame_vec: got %h expected %h at pos %0d", obs, exp_s(), pos);
            end
            if (!vsync) vs_low++;
            if (frame_tick) begin
                tk_cnt++; tk_h = int'(hcount); tk_v = int'(vcount);
            end
            if (i > 0 && ph == 10'(HT - 1) && pv == 10'(VT - 1)) begin
                wraps++;
                checks++;
                if (obs[24:2] !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
                    errors++; $display("FAIL frame_wrap: got %h expected 0/0/1/1/1", obs[24:2]);
                end
            end
            ph = hcount; pv = vcount;
            if (i < FRAME) step();
        end
        checks++;
        if (vs_low != VS * HT) begin
            errors++; $display("FAIL vsync_len: got %0d expected %0d", vs_low, VS * HT);
        end
        checks++;
        if (tk_cnt != 1 || tk_h != 0 || tk_v != VA) begin
            errors++; $display("FAIL frame_tick_once: got %0d at (%0d,%0d) expected 1 at (0,%0d)",
                               tk_cnt, tk_h, tk_v, VA);
        end
        checks++;
        if (wraps != 1) begin
            errors++; $display("FAIL frame_wrap_seen: got %0d expected 1", wraps);
        end
    endtask

    task automatic test_sec();
        int tk, rises, rise1, rise2, fall1;
        logic psec;
        do_reset();
        ce = 1'b1;
        tk = 0; rises = 0; rise1 = -1; rise2 = -1; fall1 = -1;
        psec = sec;
        for (int i = 0; i < (2 * FPS) * FRAME + FRAME / 2; i++) begin
            step();
            checks++;
            if (obs !== exp_s()) begin
                errors++; $display("FAIL sec_vec: got %h expected %h at pos %0d", obs, exp_s(), pos);
            end
            if (frame_tick) tk++;
            if (sec && !psec) begin
                rises++;
                if (rise1 < 0) rise1 = tk; else rise2 = tk;
            end
            if (!sec && psec && fall1 < 0) fall1 = tk;
            psec = sec;
        end
        checks++;
        if (rises != 2 || rise1 != FPS / 2 || rise2 != FPS / 2 + FPS || fall1 != FPS) begin
            errors++; $display("FAIL sec_edges: got rises %0d at %0d,%0d fall %0d expected 2 at %0d,%0d fall %0d",
                               rises, rise1, rise2, fall1, FPS / 2, FPS / 2 + FPS, FPS);
        end
    endtask

    task automatic test_ce_quarter();
        logic [24:0] prev;
        logic prev_ce;
        int tk_cnt;
        do_reset();
        tk_cnt = 0;
        prev = obs;
        prev_ce = 1'b0;
        for (int i = 0; i < 4 * FRAME + 8; i++) begin
            ce = (i % 4 == 0);
            prev_ce = ce;
            step();
            checks++;
            if (obs !== exp_s()) begin
                errors++; $display("FAIL quarter_vec: got %h expected %h at pos %0d", obs, exp_s(), pos);
            end
            if (!prev_ce) begin
                checks++;
                if ({obs[24:2], obs[0]} !== {prev[24:2], prev[0]}) begin
                    errors++; $display("FAIL quarter_frozen: got %h expected %h", obs, prev);
                end
            end
            if (frame_tick) begin
                tk_cnt++;
                checks++;
                if (prev[1]) begin
                    errors++; $display("FAIL quarter_tick_width: got 2+ cycles expected 1");
                end
            end
            prev = obs;
        end
        checks++;
        if (tk_cnt != 1) begin
            errors++; $display("FAIL quarter_tick_count: got %0d expected 1", tk_cnt);
        end
    endtask

    task automatic test_random_ce();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            step();
            checks++;
            if (obs !== exp_s()) begin
                errors++; $display("FAIL random_vec: got %h expected %h at pos %0d", obs, exp_s(), pos);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        int tk, rise_at;
        do_reset();
        ce = 1'b1;
        found = 0;
        for (int i = 0; i < 8 * FRAME && !found; i++) begin
            step();
            found = ((pos % HT) == 15) && (((pos / HT) % VT) == 6) && (ticks >= FPS / 2);
        end
        checks++;
        if (!found || obs !== exp_s() || sec !== 1'b1) begin
            errors++; $display("FAIL midreset_setup: got found %0d obs %h expected %h with sec 1",
                               found, obs, exp_s());
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL midreset_async: got %h expected %h", obs, RESET_VEC);
        end
        step();
        step();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL midreset_held: got %h expected %h", obs, RESET_VEC);
        end
        rst_n = 1'b1;
        ce = 1'b0;
        step();
        step();
        checks++;
        if (hcount !== 10'd0) begin
            errors++; $display("FAIL midreset_hold: got %0d expected 0", hcount);
        end
        ce = 1'b1;
        step();
        checks++;
        if (hcount !== 10'd1) begin
            errors++; $display("FAIL midreset_restart: got %0d expected 1", hcount);
        end
        tk = 0; rise_at = -1;
        for (int i = 0; i < (FPS / 2 + 1) * FRAME && rise_at < 0; i++) begin
            step();
            checks++;
            if (obs !== exp_s()) begin
                errors++; $display("FAIL midreset_vec: got %h expected %h at pos %0d", obs, exp_s(), pos);
            end
            if (frame_tick) tk++;
            if (sec) rise_at = tk;
        end
        checks++;
        if (rise_at != FPS / 2) begin
            errors++; $display("FAIL midreset_sec: got rise at tick %0d expected %0d", rise_at, FPS / 2);
        end
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_frame();
        test_sec();
        test_ce_quarter();
        test_random_ce();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
